raster_scan_gen: RTL and testbench
==================================

# raster_scan_gen

Raster timing source for the video path: generates the pixel strobe, the `DrawX`/`DrawY` scan coordinates, sync, and data-enable that the color mapper consumes to produce RGB. It runs from the system clock, divides it down to the pixel rate, and walks a 640x480@60 (800x525 total) raster. It also supplies a per-frame pulse and a frame counter for frame-rate game logic (ball/piece motion).

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; legal range 1..16.
- `H_VISIBLE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_VISIBLE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- Derived: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525). Both totals must be ≤ 1024.

Ports:
- `Clk`  in  1  system clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `pix_en`  out  1  pixel strobe; high for 1 Clk in every CLK_DIV.
- `DrawX`  out  10  current column, 0..H_TOTAL-1.
- `DrawY`  out  10  current line, 0..V_TOTAL-1.
- `hs`  out  1  horizontal sync, active low.
- `vs`  out  1  vertical sync, active low.
- `vde`  out  1  video data enable; high inside the visible region.
- `frame_start`  out  1  one-Clk pulse marking entry into pixel (0,0).
- `frame_count`  out  8  frames started since reset; wraps 255→0.

## Operation
- Divider:
  - `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (div == CLK_DIV-1), registered so it is glitch-free.
  - With CLK_DIV=1, `pix_en` is constantly high once reset is released.
- Counters (`DrawX`/`DrawY`) advance only on an edge where `pix_en` is high:
  - If DrawX < H_TOTAL-1, DrawX increments.
  - Otherwise DrawX goes to 0 and DrawY advances: it increments, or wraps to 0 when it equals V_TOTAL-1.
- Decodes (registered from next-state counter values, so they change on the same edge as the counters):
  - `vde` = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
  - `hs` = 0 iff H_VISIBLE+H_FP ≤ DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
  - `vs` = 0 iff V_VISIBLE+V_FP ≤ DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
- Frame events:
  - On the edge where the counters wrap to (0,0), `frame_start` is registered high for exactly one Clk.
  - On that same edge `frame_count` increments.
- Reset (synchronous, overrides everything):
  - div=0, DrawX=H_TOTAL-1 (799), DrawY=V_TOTAL-1 (524).
  - hs=1, vs=1, vde=0, pix_en=0, frame_start=0, frame_count=0.
  - Parking on the last blanked pixel makes the first strobe after reset start frame 0 cleanly.
- Reset mid-frame: on the next edge all state returns to the reset values above, regardless of position. There is no partial line.

## Timing
- Reset is released at edge E0. `pix_en` is high during cycle CLK_DIV-1 after E0, i.e. cycle 3 at the default.
- The next edge moves the counters to (0,0), sets vde=1 and frame_start=1, and sets frame_count to 1.
- Latency from counter change to hs/vs/vde change: 0 cycles (same edge).
- `DrawX` holds each value for CLK_DIV Clk cycles.
- Line period = H_TOTAL·CLK_DIV Clk (3200). Frame period = H_TOTAL·V_TOTAL·CLK_DIV Clk (1,680,000).
- `frame_start` is high for 1 Clk, not 1 pixel. Consumers using it as a frame clock must treat it as an enable.
- `vs` assertion lines up with the DrawX 799→0 edge entering line 490. `vs` deassertion lines up with the same edge entering line 492.
- `vde` falls on the edge DrawX 639→640 and rises on 799→0 only when the new DrawY < 480.

## Test plan
- Reset held 5 cycles, then released → DrawX=799, DrawY=524, hs=vs=1, vde=0 during reset. pix_en first high 3 cycles after release; the next cycle shows DrawX=0, DrawY=0, vde=1, frame_start=1, frame_count=1.
- Free run, 2 full lines → pix_en period exactly 4 Clk; each line 3200 Clk. hs low for exactly 96 pixels (384 Clk) starting at DrawX=656. vde high for DrawX 0..639 only.
- Free run, 2 full frames → frame_start pulses exactly 1,680,000 Clk apart, each 1 Clk wide. vs low only for DrawY 490..491 (1600 pixels). vde never high for DrawY ≥ 480. frame_count = 2.
- Reset asserted while DrawX=300, DrawY=200 → on the next edge all outputs show reset values. After release, the raster restarts at (0,0) with frame_count=1.
- CLK_DIV=1 build → pix_en stays high after release. Frame period is 420,000 Clk and all sync positions are unchanged in pixel units.
- 256 frames run (reduced-size parameters allowed, e.g. 8x4 visible) → frame_count wraps 255→0 on the 256th frame_start. The counters never exceed the H_TOTAL-1 / V_TOTAL-1 limits.

Source files
------------

// File: rtl/raster_scan_gen.sv
// Raster timing source: pixel strobe, scan coordinates, sync, data enable,
// and frame pulse/counter for a divided-down pixel clock.
module raster_scan_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       vde,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] H_SS     = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SE     = 11'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] V_SS     = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SE     = 11'(V_VISIBLE + V_FP + V_SYNC);

    logic [3:0] div_q, div_d;
    logic       pix_en_q, pix_en_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       vde_q, vde_d;
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;

    logic [10:0] x_ext, y_ext;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        pix_en_d = (div_d == DIV_LAST);
        x_d      = x_q;
        y_d      = y_q;
        fs_d     = 1'b0;
        fc_d     = fc_q;
        if (pix_en_q) begin
            if (x_q < H_LAST) begin
                x_d = x_q + 10'd1;
            end else begin
                x_d = 10'd0;
                if (y_q < V_LAST) begin
                    y_d = y_q + 10'd1;
                end else begin
                    y_d  = 10'd0;
                    fs_d = 1'b1;
                    fc_d = fc_q + 8'd1;
                end
            end
        end
        // Decode from next-state counters so syncs move on the counter edge
        x_ext = {1'b0, x_d};
        y_ext = {1'b0, y_d};
        vde_d = (x_ext < H_VIS) && (y_ext < V_VIS);
        hs_d  = !((x_ext >= H_SS) && (x_ext < H_SE));
        vs_d  = !((y_ext >= V_SS) && (y_ext < V_SE));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q    <= 4'd0;
            pix_en_q <= 1'b0;
            x_q      <= H_LAST;
            y_q      <= V_LAST;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            vde_q    <= 1'b0;
            fs_q     <= 1'b0;
            fc_q     <= 8'd0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            vde_q    <= vde_d;
            fs_q     <= fs_d;
            fc_q     <= fc_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vde         = vde_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Scoreboard bench for raster_scan_gen on a reduced 10x6 raster,
// one instance at CLK_DIV=4 and one at CLK_DIV=1.
module tb_raster_scan_gen;

    typedef struct {
        int cyc;
        int x;
        int y;
        int hs;
        int vs;
        int vde;
        int pe;
        int fc;
    } probe_t;

    typedef struct {
        int cyc;
        int fc;
    } fev_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int   cyc_cnt = 0;
    int   tests = 0;
    int   fails = 0;

    probe_t pq4[$];
    probe_t pq1[$];
    fev_t   fq4[$];
    fev_t   fq1[$];
    probe_t pv4, pv1;
    fev_t   fv4, fv1;

    logic       pe4, hs4, vs4, vde4, fs4;
    logic [9:0] x4, y4;
    logic [7:0] fc4;
    logic       pe1, hs1, vs1, vde1, fs1;
    logic [9:0] x1, y1;
    logic [7:0] fc1;

    raster_scan_gen #(
        .CLK_DIV(4), .H_VISIBLE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut4 (
        .Clk(Clk), .Reset(Reset), .pix_en(pe4), .DrawX(x4), .DrawY(y4),
        .hs(hs4), .vs(vs4), .vde(vde4), .frame_start(fs4),
        .frame_count(fc4)
    );

    raster_scan_gen #(
        .CLK_DIV(1), .H_VISIBLE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut1 (
        .Clk(Clk), .Reset(Reset), .pix_en(pe1), .DrawX(x1), .DrawY(y1),
        .hs(hs1), .vs(vs1), .vde(vde1), .frame_start(fs1),
        .frame_count(fc1)
    );

    always #5 Clk = ~Clk;

    // Edges since the last edge that sampled Reset high
    always @(posedge Clk) cyc_cnt <= Reset ? 0 : cyc_cnt + 1;

    task automatic cmp(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                     nm, cyc_cnt, act, exp);
        end
    endtask

    task automatic p4(input int c, input int x, input int y, input int h,
                      input int v, input int d, input int p, input int f);
        pq4.push_back('{c, x, y, h, v, d, p, f});
    endtask

    task automatic p1(input int c, input int x, input int y, input int h,
                      input int v, input int d, input int p, input int f);
        pq1.push_back('{c, x, y, h, v, d, p, f});
    endtask

    task automatic drain();
        foreach (pq4[i]) begin
            tests++; fails++;
            $display("FAIL d4_probe_missed cyc=%0d", pq4[i].cyc);
        end
        foreach (pq1[i]) begin
            tests++; fails++;
            $display("FAIL d1_probe_missed cyc=%0d", pq1[i].cyc);
        end
        foreach (fq4[i]) begin
            tests++; fails++;
            $display("FAIL d4_frame_missed cyc=%0d", fq4[i].cyc);
        end
        foreach (fq1[i]) begin
            tests++; fails++;
            $display("FAIL d1_frame_missed cyc=%0d", fq1[i].cyc);
        end
        pq4.delete(); pq1.delete(); fq4.delete(); fq1.delete();
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 100000; i++) begin
            if (cyc_cnt == target) return;
            @(posedge Clk);
            #1;
        end
        tests++; fails++;
        $display("FAIL wait_timeout got=%0d expected=%0d", cyc_cnt, target);
    endtask

    always @(negedge Clk) begin
        if (pq4.size() > 0 && pq4[0].cyc == cyc_cnt) begin
            pv4 = pq4.pop_front();
            cmp("d4_x", int'(x4), pv4.x);
            cmp("d4_y", int'(y4), pv4.y);
            cmp("d4_hs", int'(hs4), pv4.hs);
            cmp("d4_vs", int'(vs4), pv4.vs);
            cmp("d4_vde", int'(vde4), pv4.vde);
            cmp("d4_pix_en", int'(pe4), pv4.pe);
            cmp("d4_fc", int'(fc4), pv4.fc);
        end
        if (fs4) begin
            if (fq4.size() == 0) begin
                tests++; fails++;
                $display("FAIL d4_frame_unexpected cyc=%0d got=1 expected=0",
                         cyc_cnt);
            end else begin
                fv4 = fq4.pop_front();
                cmp("d4_fs_cyc", cyc_cnt, fv4.cyc);
                cmp("d4_fs_fc", int'(fc4), fv4.fc);
                cmp("d4_fs_x", int'(x4), 0);
                cmp("d4_fs_y", int'(y4), 0);
                cmp("d4_fs_vde", int'(vde4), 1);
            end
        end
        cmp("d4_pix_period", int'(pe4), int'(cyc_cnt % 4 == 3));
        cmp("d4_limits", int'(x4 <= 10'd9 && y4 <= 10'd5), 1);
    end

    always @(negedge Clk) begin
        if (pq1.size() > 0 && pq1[0].cyc == cyc_cnt) begin
            pv1 = pq1.pop_front();
            cmp("d1_x", int'(x1), pv1.x);
            cmp("d1_y", int'(y1), pv1.y);
            cmp("d1_hs", int'(hs1), pv1.hs);
            cmp("d1_vs", int'(vs1), pv1.vs);
            cmp("d1_vde", int'(vde1), pv1.vde);
            cmp("d1_pix_en", int'(pe1), pv1.pe);
            cmp("d1_fc", int'(fc1), pv1.fc);
        end
        if (fs1) begin
            if (fq1.size() == 0) begin
                tests++; fails++;
                $display("FAIL d1_frame_unexpected cyc=%0d got=1 expected=0",
                         cyc_cnt);
            end else begin
                fv1 = fq1.pop_front();
                cmp("d1_fs_cyc", cyc_cnt, fv1.cyc);
                cmp("d1_fs_fc", int'(fc1), fv1.fc);
            end
        end
        cmp("d1_pix_high", int'(pe1), int'(cyc_cnt >= 1));
        cmp("d1_limits", int'(x1 <= 10'd9 && y1 <= 10'd5), 1);
    end

    initial begin
        // cyc  x  y hs vs vde pe fc ; pixel (x,y) starts at cyc 4+4*(10y+x)
        p4(0,     9, 5, 1, 1, 0, 0, 0);
        p4(2,     9, 5, 1, 1, 0, 0, 0);
        p4(3,     9, 5, 1, 1, 0, 1, 0);
        p4(4,     0, 0, 1, 1, 1, 0, 1);
        p4(7,     0, 0, 1, 1, 1, 1, 1);
        p4(24,    5, 0, 1, 1, 1, 0, 1);
        p4(28,    6, 0, 1, 1, 0, 0, 1);
        p4(32,    7, 0, 0, 1, 0, 0, 1);
        p4(39,    8, 0, 0, 1, 0, 1, 1);
        p4(40,    9, 0, 1, 1, 0, 0, 1);
        p4(44,    0, 1, 1, 1, 1, 0, 1);
        p4(124,   0, 3, 1, 1, 0, 0, 1);
        p4(160,   9, 3, 1, 1, 0, 0, 1);
        p4(164,   0, 4, 1, 0, 0, 0, 1);
        p4(203,   9, 4, 1, 0, 0, 1, 1);
        p4(204,   0, 5, 1, 1, 0, 0, 1);
        p4(243,   9, 5, 1, 1, 0, 1, 1);
        p4(244,   0, 0, 1, 1, 1, 0, 2);
        p4(61540, 4, 2, 1, 1, 1, 0, 1);
        // CLK_DIV=1: pixel (x,y) at cyc 2+(10y+x)
        p1(0,     9, 5, 1, 1, 0, 0, 0);
        p1(1,     9, 5, 1, 1, 0, 1, 0);
        p1(2,     0, 0, 1, 1, 1, 1, 1);
        p1(9,     7, 0, 0, 1, 0, 1, 1);
        p1(10,    8, 0, 0, 1, 0, 1, 1);
        p1(11,    9, 0, 1, 1, 0, 1, 1);
        p1(42,    0, 4, 1, 0, 0, 1, 1);
        p1(52,    0, 5, 1, 1, 0, 1, 1);
        p1(61540, 8, 3, 0, 1, 0, 1, 2);
        for (int n = 0; n <= 256; n++) fq4.push_back('{4 + 240 * n, (n + 1) % 256});
        for (int n = 0; n <= 1025; n++) fq1.push_back('{2 + 60 * n, (n + 1) % 256});

        repeat (5) @(posedge Clk);
        #1 Reset = 1'b0;
        wait_cyc(61541);

        drain();
        p4(0, 9, 5, 1, 1, 0, 0, 0);
        p4(3, 9, 5, 1, 1, 0, 1, 0);
        p4(4, 0, 0, 1, 1, 1, 0, 1);
        p1(0, 9, 5, 1, 1, 0, 0, 0);
        p1(2, 0, 0, 1, 1, 1, 1, 1);
        fq4.push_back('{4, 1});
        fq4.push_back('{244, 2});
        for (int n = 0; n <= 4; n++) fq1.push_back('{2 + 60 * n, n + 1});
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        wait_cyc(300);
        @(negedge Clk);
        #1;
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
